aca_share_arbiter: RTL and testbench

- Shares one pipelined almost-correct 16-bit adder between two requesters using round-robin arbitration.
- Issues at most one operand pair per cycle and tags each issue with its requester ID.
- Routes each result back to the requester that issued it, after the adder latency.
- Supports a flush/drain sequence before the adder is reconfigured or idled.

---
 rtl/aca_pkg.sv | 16 +
 rtl/aca_tag_pipe.sv | 73 +++++++
 rtl/aca_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_aca_share_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aca_pkg.sv
// Shared defaults, FSM encoding and requester-id type for the ACA share arbiter.
package aca_pkg;

  localparam int ACA_W       = 16;
  localparam int ACA_ADD_LAT = 1;
  localparam int ID_W        = 1;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/aca_tag_pipe.sv
// DEPTH-stage shift register of {valid, id} (plus operands when ACA_ERR_CHECK_EN is defined)
// that tracks issues in flight through the shared adder and reports how many are in flight.
module aca_tag_pipe
  import aca_pkg::*;
#(
  parameter int DEPTH = ACA_ADD_LAT,
`ifdef ACA_ERR_CHECK_EN
  parameter int W     = ACA_W,
`endif
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  req_id_t       in_id,
`ifdef ACA_ERR_CHECK_EN
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b,
`endif
  output logic          out_valid,
  output req_id_t       out_id,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] vld;
  req_id_t          id_q [DEPTH];
`ifdef ACA_ERR_CHECK_EN
  logic [W-1:0]     a_q  [DEPTH];
  logic [W-1:0]     b_q  [DEPTH];
`endif

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the shift into one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
    end
  end

  // NOTE: payload stages are not reset; vld alone qualifies them, so clearing the data
  // would only add reset fan-out to what is effectively a memory.
  always_ff @(posedge clk) begin
    id_q[0] <= in_id;
    for (int i = 1; i < DEPTH; i++) id_q[i] <= id_q[i-1];
`ifdef ACA_ERR_CHECK_EN
    a_q[0] <= in_a;
    b_q[0] <= in_b;
    for (int i = 1; i < DEPTH; i++) begin
      a_q[i] <= a_q[i-1];
      b_q[i] <= b_q[i-1];
    end
`endif
  end

  // NOTE: the accumulator gets its default before the loop, so no latch is inferred.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(vld[i]);
  end

  assign out_valid = vld[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];
`ifdef ACA_ERR_CHECK_EN
  assign out_a     = a_q[DEPTH-1];
  assign out_b     = b_q[DEPTH-1];
`endif

endmodule

// File: rtl/aca_share_arbiter.sv
// Round-robin sharing of one pipelined almost-correct adder between two requesters, with a
// flush/drain sequence. Define ACA_ERR_CHECK_EN to add the exact-sum check and err_count.
module aca_share_arbiter
  import aca_pkg::*;
#(
  parameter int W       = ACA_W,
  parameter int ADD_LAT = ACA_ADD_LAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         resp0_valid,
  output logic         resp1_valid,
  output logic [W-1:0] resp_sum,
  output logic         resp_cout,
  output logic         resp_err,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_valid,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  input  logic         flush,
  output logic         flush_done,
  output logic         busy
);

  localparam int CW = $clog2(ADD_LAT + 1);

  state_t        state, state_next;
  req_id_t       rr;
  logic          can_grant, grant0, grant1, grant;
  logic          ret_valid;
  req_id_t       ret_id;
  logic [CW-1:0] inflight;

  // A flush in RUN suppresses that cycle's grant; reset also blocks any handshake.
  assign can_grant  = (state == RUN) && !flush && !rst;
  assign grant0     = can_grant && req0_valid && (!req1_valid || rr == 1'b0);
  assign grant1     = can_grant && req1_valid && (!req0_valid || rr == 1'b1);
  assign grant      = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign add_valid  = grant;
  assign add_a      = grant1 ? req1_a : (grant0 ? req0_a : '0);
  assign add_b      = grant1 ? req1_b : (grant0 ? req0_b : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      rr    <= '0;
    end else begin
      state <= state_next;
      if (grant) rr <= grant1 ? 1'b0 : 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   if (inflight == '0) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign flush_done = (state == DONE);
  assign busy       = (inflight != '0) || (state != RUN);

`ifdef ACA_ERR_CHECK_EN
  logic [W-1:0] ret_a, ret_b;
`endif

  aca_tag_pipe #(
    .DEPTH (ADD_LAT)
`ifdef ACA_ERR_CHECK_EN
    , .W   (W)
`endif
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (grant),
    .in_id     (grant1),
`ifdef ACA_ERR_CHECK_EN
    .in_a      (add_a),
    .in_b      (add_b),
    .out_a     (ret_a),
    .out_b     (ret_b),
`endif
    .out_valid (ret_valid),
    .out_id    (ret_id),
    .count     (inflight)
  );

  // Result is captured as its tag leaves the pipe; the routed pulse follows one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_sum    <= '0;
      resp_cout   <= 1'b0;
    end else begin
      resp0_valid <= ret_valid && (ret_id == 1'b0);
      resp1_valid <= ret_valid && (ret_id == 1'b1);
      if (ret_valid) begin
        resp_sum  <= add_sum;
        resp_cout <= add_cout;
      end
    end
  end

`ifdef ACA_ERR_CHECK_EN
  logic [W:0]  exact;
  logic        mismatch;
  logic [15:0] err_count;

  assign exact    = {1'b0, ret_a} + {1'b0, ret_b};
  assign mismatch = ret_valid && ({add_cout, add_sum} != exact);

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err  <= 1'b0;
      err_count <= '0;
    end else begin
      resp_err <= mismatch;
      if (mismatch && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_aca_share_arbiter.sv
// Directed self-checking bench for aca_share_arbiter with a one-cycle adder model that can
// be told to return a wrong sum for 255+1.
module tb_aca_share_arbiter;

  localparam int W = 16;
`ifdef ACA_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         resp0_valid, resp1_valid;
  logic [W-1:0] resp_sum;
  logic         resp_cout, resp_err;
  logic [W-1:0] add_a, add_b;
  logic         add_valid;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic         flush = 1'b0;
  logic         flush_done, busy;
  logic         inject = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  int          pulse0 = 0, pulse1 = 0;
  logic [W:0]  q0 [$];
  logic [W:0]  q1 [$];
  int          order [$];

  always #5 clk = ~clk;

  aca_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_err(resp_err),
    .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
    .add_sum(add_sum), .add_cout(add_cout),
    .flush(flush), .flush_done(flush_done), .busy(busy)
  );

  // Adder model: one-cycle latency, exact unless the 255+1 fault is enabled.
  always @(posedge clk) begin
    if (inject && add_a == 16'd255 && add_b == 16'd1) {add_cout, add_sum} <= '0;
    else {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b};
  end

  // Response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (resp0_valid) begin
      pulse0++;
      q0.push_back({resp_cout, resp_sum});
      order.push_back(0);
    end
    if (resp1_valid) begin
      pulse1++;
      q1.push_back({resp_cout, resp_sum});
      order.push_back(1);
    end
  end

  // Advance to the next falling edge, after the monitor has sampled.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic apply_reset();
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q0.delete(); q1.delete(); order.delete();
  endtask

  task automatic test_reset();
    step();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; flush = 1'b1;
    step();
    #1;
    if ({req0_ready, req1_ready, add_valid} !== 3'b000) begin
      $display("FAIL reset_grants: got %b want 000", {req0_ready, req1_ready, add_valid}); tests_failed++;
    end
    tests_run++;
    if ({resp0_valid, resp1_valid, resp_cout, resp_err, flush_done, busy} !== 6'b0) begin
      $display("FAIL reset_flags: got %b want 000000",
               {resp0_valid, resp1_valid, resp_cout, resp_err, flush_done, busy}); tests_failed++;
    end
    tests_run++;
    if ({resp_sum, add_a, add_b} !== '0) begin
      $display("FAIL reset_data: sum %h a %h b %h want 0", resp_sum, add_a, add_b); tests_failed++;
    end
    tests_run++;
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    step();  // cycle 0
    req0_valid = 1'b1; req0_a = 16'd52; req0_b = 16'd66;
    #1;
    if ({req0_ready, req1_ready, add_valid} !== 3'b101 || add_a !== 16'd52 || add_b !== 16'd66) begin
      $display("FAIL single_issue: rdy/av %b a %0d b %0d want 101 52 66",
               {req0_ready, req1_ready, add_valid}, add_a, add_b); tests_failed++;
    end
    tests_run++;
    step();  // cycle 1
    req0_valid = 1'b0;
    if (resp0_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL single_c1: resp0 %b busy %b want 0 1", resp0_valid, busy); tests_failed++;
    end
    tests_run++;
    step();  // cycle 2
    if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp_sum !== 16'd118 ||
        resp_cout !== 1'b0 || resp_err !== 1'b0) begin
      $display("FAIL single_resp: v0 %b v1 %b sum %0d cout %b err %b want 1 0 118 0 0",
               resp0_valid, resp1_valid, resp_sum, resp_cout, resp_err); tests_failed++;
    end
    tests_run++;
    step();  // cycle 3
    if (resp0_valid !== 1'b0 || resp_sum !== 16'd118 || busy !== 1'b0) begin
      $display("FAIL single_hold: v0 %b sum %0d busy %b want 0 118 0", resp0_valid, resp_sum, busy);
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_contention();
    apply_reset();
    req0_a = 16'd50;  req0_b = 16'd40;
    req1_a = 16'd512; req1_b = 16'd512;
    for (int k = 0; k < 4; k++) begin
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01) ||
          add_a !== ((k % 2 == 0) ? 16'd50 : 16'd512)) begin
        $display("FAIL contention_grant%0d: rdy %b a %0d", k, {req0_ready, req1_ready}, add_a);
        tests_failed++;
      end
      tests_run++;
    end
    step();
    idle_inputs();
    step(); step();
    if (q0.size() != 2 || q1.size() != 2) begin
      $display("FAIL contention_count: q0 %0d q1 %0d want 2 2", q0.size(), q1.size()); tests_failed++;
    end else if (q0[0] !== 17'd90 || q0[1] !== 17'd90 || q1[0] !== 17'd1024 || q1[1] !== 17'd1024) begin
      $display("FAIL contention_sums: %0d %0d %0d %0d want 90 90 1024 1024", q0[0], q0[1], q1[0], q1[1]);
      tests_failed++;
    end
    tests_run++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      $display("FAIL contention_order: size %0d want 0,1,0,1", order.size()); tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_wrap_carry();
    step();  // cycle 0: req1 alone wins even with pointer at 0
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'd1;
    #1;
    if (req1_ready !== 1'b1) begin
      $display("FAIL wrap_grant: req1_ready %b want 1", req1_ready); tests_failed++;
    end
    tests_run++;
    step();
    req1_valid = 1'b0;
    step();  // cycle 2
    if (resp1_valid !== 1'b1 || resp_sum !== 16'd0 || resp_cout !== 1'b1) begin
      $display("FAIL wrap_resp: v1 %b sum %h cout %b want 1 0000 1", resp1_valid, resp_sum, resp_cout);
      tests_failed++;
    end
    tests_run++;
    req0_valid = 1'b1; req0_a = 16'd31728; req0_b = 16'd32650;
    step();
    req0_valid = 1'b0;
    step();
    if (resp0_valid !== 1'b1 || resp_sum !== 16'd64378 || resp_cout !== 1'b0) begin
      $display("FAIL nocarry_resp: v0 %b sum %0d cout %b want 1 64378 0", resp0_valid, resp_sum, resp_cout);
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_flush();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      req0_valid = 1'b1; req0_a = 16'(k + 1); req0_b = 16'(k + 1);
    end
    step();  // cycle 3
    flush = 1'b1;
    #1;
    if (req0_ready !== 1'b0 || add_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL flush_suppress: rdy %b av %b busy %b want 0 0 1", req0_ready, add_valid, busy);
      tests_failed++;
    end
    tests_run++;
    step();  // cycle 4: DRAIN, last response
    flush = 1'b0;
    #1;
    if (req0_ready !== 1'b0 || resp0_valid !== 1'b1 || resp_sum !== 16'd6 ||
        flush_done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL flush_drain: rdy %b v0 %b sum %0d fd %b busy %b want 0 1 6 0 1",
               req0_ready, resp0_valid, resp_sum, flush_done, busy); tests_failed++;
    end
    tests_run++;
    step();  // cycle 5: DONE
    if (flush_done !== 1'b1 || req0_ready !== 1'b0 || resp0_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL flush_done: fd %b rdy %b v0 %b busy %b want 1 0 0 1",
               flush_done, req0_ready, resp0_valid, busy); tests_failed++;
    end
    tests_run++;
    req0_valid = 1'b0;
    step();  // cycle 6: back in RUN
    if (flush_done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL flush_after: fd %b busy %b want 0 0", flush_done, busy); tests_failed++;
    end
    tests_run++;
    if (q0.size() != 3 || q0[0] !== 17'd2 || q0[1] !== 17'd4 || q0[2] !== 17'd6) begin
      $display("FAIL flush_results: count %0d want 3 (2,4,6)", q0.size()); tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_err_check();
    apply_reset();
    inject = 1'b1;
    step();
    req0_valid = 1'b1; req0_a = 16'd255; req0_b = 16'd1;
    step();
    req0_valid = 1'b0;
    step();  // response to faulty add
    if (resp0_valid !== 1'b1 || resp_sum !== 16'd0 || resp_err !== ERR_EN) begin
      $display("FAIL err_flag: v0 %b sum %0d err %b want 1 0 %b", resp0_valid, resp_sum, resp_err, ERR_EN);
      tests_failed++;
    end
    tests_run++;
`ifdef ACA_ERR_CHECK_EN
    if (dut.err_count !== 16'd1) begin
      $display("FAIL err_count1: got %0d want 1", dut.err_count); tests_failed++;
    end
    tests_run++;
`endif
    req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd4;
    step();
    req0_valid = 1'b0;
    if (resp_err !== 1'b0) begin
      $display("FAIL err_pulse: err %b want 0", resp_err); tests_failed++;
    end
    tests_run++;
    step();
    if (resp0_valid !== 1'b1 || resp_sum !== 16'd7 || resp_err !== 1'b0) begin
      $display("FAIL err_exact: v0 %b sum %0d err %b want 1 7 0", resp0_valid, resp_sum, resp_err);
      tests_failed++;
    end
    tests_run++;
`ifdef ACA_ERR_CHECK_EN
    if (dut.err_count !== 16'd1) begin
      $display("FAIL err_count_hold: got %0d want 1", dut.err_count); tests_failed++;
    end
    tests_run++;
`endif
    inject = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int snap0, snap1;
    apply_reset();
    step();  // cycle 0: req1 wins, pointer -> 0
    req1_valid = 1'b1; req1_a = 16'd1; req1_b = 16'd1;
    step();  // cycle 1: req0 wins, pointer -> 1
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 16'd2; req0_b = 16'd2;
    step();  // cycle 2: reset for one cycle
    req0_valid = 1'b0;
    rst = 1'b1;
    step();  // cycle 3
    rst = 1'b0;
    snap0 = pulse0; snap1 = pulse1;
    if (busy !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      $display("FAIL midrst_clear: busy %b v0 %b v1 %b want 0 0 0", busy, resp0_valid, resp1_valid);
      tests_failed++;
    end
    tests_run++;
    step(); step(); step();
    if (pulse0 != snap0 || pulse1 != snap1) begin
      $display("FAIL midrst_nopulse: extra pulses r0 %0d r1 %0d want 0 0", pulse0 - snap0, pulse1 - snap1);
      tests_failed++;
    end
    tests_run++;
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL midrst_pointer: rdy %b want 10", {req0_ready, req1_ready}); tests_failed++;
    end
    tests_run++;
    step();
    idle_inputs();
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap_carry();
    test_flush();
    test_err_check();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
